// File: rtl/sdu_rx_framer.sv
// Receive framer: splits playback bursts into packets of at most PKT_WORDS words,
// buffers them with sof/eof sideband and queues one descriptor per packet.
module sdu_rx_framer #(
    parameter int PKT_WORDS = 128,
    parameter int DATA_AW   = 9,
    parameter int DESC_AW   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_start,
    input  logic [31:0] in_data,
    input  logic        in_strobe,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] desc_data,
    output logic        desc_valid,
    input  logic        desc_ready,
    input  logic        clear_stats,
    output logic        overrun,
    output logic [15:0] dropped_frames
);
    localparam int          DDEPTH = 1 << DATA_AW;
    localparam int          QDEPTH = 1 << DESC_AW;
    localparam logic [15:0] PKT    = 16'(PKT_WORDS);

    typedef enum logic [1:0] {IDLE, FIRST, RUN, DISCARD} state_t;
    state_t r_state, w_nstate;

    logic [33:0]      r_dmem [DDEPTH];
    logic [31:0]      r_qmem [QDEPTH];
    logic [DATA_AW:0] r_dwp, r_drp, w_dcnt;
    logic [DESC_AW:0] r_qwp, r_qrp, w_qcnt;
    logic [31:0]      r_stg_data;
    logic             r_stg_sof;
    logic [15:0]      r_cnt;
    logic [7:0]       r_seq, r_idx;
    logic             r_ovr;
    logic [15:0]      r_drop;

    logic        w_flush, w_eof, w_adm, w_adm_ok, w_newframe, w_load_cont;
    logic        w_pend, w_drop, w_load_sof, w_dpop, w_qpop;
    logic [33:0] w_dhead;
    logic [31:0] w_qhead;

    assign w_dcnt = r_dwp - r_drp;
    assign w_qcnt = r_qwp - r_qrp;
    assign w_dpop = out_valid & out_ready;
    assign w_qpop = desc_valid & desc_ready;

    // Every admission made from RUN coincides with an eof flush of the stage,
    // so that same-cycle data and descriptor write is charged here.
    assign w_pend   = (r_state == RUN);
    assign w_adm_ok = (DDEPTH - int'(w_dcnt) - int'(w_pend) >= PKT_WORDS + 1) &&
                      (int'(w_qcnt) + int'(w_pend) < QDEPTH);

    always_comb begin
        w_nstate    = r_state;
        w_flush     = 1'b0;
        w_eof       = 1'b0;
        w_adm       = 1'b0;
        w_newframe  = 1'b0;
        w_load_cont = 1'b0;
        case (r_state)
            RUN: begin
                if (in_start) begin
                    w_flush    = 1'b1;
                    w_eof      = 1'b1;
                    w_newframe = 1'b1;
                    w_nstate   = FIRST;
                    w_adm      = in_strobe;
                end else if (in_strobe) begin
                    w_flush = 1'b1;
                    if (r_cnt < PKT) begin
                        w_load_cont = 1'b1;
                    end else begin
                        w_eof = 1'b1;
                        w_adm = 1'b1;
                    end
                end else begin
                    w_flush  = 1'b1;
                    w_eof    = 1'b1;
                    w_nstate = IDLE;
                end
            end
            default: begin
                if (in_start) begin
                    w_newframe = 1'b1;
                    w_nstate   = FIRST;
                end else if (r_state == FIRST && in_strobe) begin
                    w_adm = 1'b1;
                end
            end
        endcase
        if (w_adm) w_nstate = w_adm_ok ? RUN : DISCARD;
    end

    assign w_drop     = w_adm & ~w_adm_ok;
    assign w_load_sof = w_adm & w_adm_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dwp      <= '0;
            r_drp      <= '0;
            r_qwp      <= '0;
            r_qrp      <= '0;
            r_stg_data <= '0;
            r_stg_sof  <= 1'b0;
            r_cnt      <= '0;
            r_seq      <= 8'hFF;
            r_idx      <= '0;
            r_ovr      <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_load_sof) begin
                r_stg_data <= in_data;
                r_stg_sof  <= 1'b1;
                r_cnt      <= 16'd1;
            end else if (w_load_cont) begin
                r_stg_data <= in_data;
                r_stg_sof  <= 1'b0;
                r_cnt      <= r_cnt + 16'd1;
            end
            if (w_flush)         r_dwp <= r_dwp + 1'b1;
            if (w_dpop)          r_drp <= r_drp + 1'b1;
            if (w_flush & w_eof) r_qwp <= r_qwp + 1'b1;
            if (w_qpop)          r_qrp <= r_qrp + 1'b1;
            if (w_newframe) begin
                r_seq <= r_seq + 8'd1;
                r_idx <= '0;
            end else if (w_flush & w_eof) begin
                r_idx <= r_idx + 8'd1;
            end
            // A drop in the same cycle as clear_stats leaves the drop recorded.
            if (w_drop) begin
                r_ovr  <= 1'b1;
                r_drop <= clear_stats ? 16'd1 : ((r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1);
            end else if (clear_stats) begin
                r_ovr  <= 1'b0;
                r_drop <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_flush)         r_dmem[r_dwp[DATA_AW-1:0]] <= {w_eof, r_stg_sof, r_stg_data};
        if (!reset && w_flush & w_eof) r_qmem[r_qwp[DESC_AW-1:0]] <= {r_seq, r_idx, r_cnt};
    end

    assign w_dhead        = r_dmem[r_drp[DATA_AW-1:0]];
    assign w_qhead        = r_qmem[r_qrp[DESC_AW-1:0]];
    assign out_valid      = (w_dcnt != '0);
    assign out_data       = out_valid ? w_dhead[31:0] : '0;
    assign out_sof        = out_valid & w_dhead[32];
    assign out_eof        = out_valid & w_dhead[33];
    assign desc_valid     = (w_qcnt != '0);
    assign desc_data      = desc_valid ? w_qhead : '0;
    assign overrun        = r_ovr;
    assign dropped_frames = r_drop;
endmodule

// File: tb/tb_sdu_rx_framer.sv
// Bench for sdu_rx_framer: directed test-plan frames plus random bursts, scored
// against a frame/packet-level queue model of the expected FIFO contents.
module tb_sdu_rx_framer;
    localparam int PKT = 128, DDEPTH = 512, QDEPTH = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_start = 1'b0, in_strobe = 1'b0, out_ready = 1'b0, desc_ready = 1'b0, clear_stats = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] out_data, desc_data;
    logic        out_sof, out_eof, out_valid, desc_valid, overrun;
    logic [15:0] dropped_frames;

    always #5 clk = ~clk;

    sdu_rx_framer dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_data(in_data), .in_strobe(in_strobe),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .out_valid(out_valid),
        .out_ready(out_ready), .desc_data(desc_data), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .clear_stats(clear_stats), .overrun(overrun),
        .dropped_frames(dropped_frames)
    );

    int          n_chk = 0, n_pass = 0, n_popped = 0;
    logic [33:0] exp_q[$];          // {eof, sof, data} accepted and not yet popped
    logic [31:0] desc_q[$];
    logic [31:0] got_desc[$];
    logic [33:0] last_word = '0;
    int          m_mode = 0;        // 0 ignoring strobes, 1 awaiting first word, 2 packet open
    int          m_cnt = 0;
    logic [7:0]  m_seq = 8'hFF, m_idx = '0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_drop = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    task automatic m_close();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1][33] = 1'b1;
        desc_q.push_back({m_seq, m_idx, 16'(m_cnt)});
        m_idx++;
        m_mode = 0;
    endtask

    task automatic m_admit(input logic [31:0] d, input logic clr, output bit dropped);
        dropped = 0;
        if (DDEPTH - exp_q.size() >= PKT + 1 && desc_q.size() < QDEPTH) begin
            exp_q.push_back({2'b01, d});
            m_cnt  = 1;
            m_mode = 2;
        end else begin
            m_mode  = 0;
            m_ovr   = 1'b1;
            m_drop  = clr ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
            dropped = 1;
        end
    endtask

    task automatic m_step(input logic st, input logic sb, input logic [31:0] d, input logic clr);
        bit dropped, was_open;
        dropped  = 0;
        was_open = (m_mode == 2);
        if (st) begin
            if (was_open) m_close();
            m_seq++;
            m_idx  = '0;
            m_mode = 1;
            if (was_open && sb) m_admit(d, clr, dropped);
        end else if (sb && m_mode == 1) begin
            m_admit(d, clr, dropped);
        end else if (sb && m_mode == 2) begin
            if (m_cnt < PKT) begin
                exp_q.push_back({2'b00, d});
                m_cnt++;
            end else begin
                m_close();
                m_admit(d, clr, dropped);
            end
        end else if (!sb && m_mode == 2) begin
            m_close();
        end
        if (clr && !dropped) begin
            m_ovr  = 1'b0;
            m_drop = '0;
        end
    endtask

    task automatic cyc(input logic st, input logic sb, input logic [31:0] d,
                       input logic ordy, input logic drdy, input logic clr);
        @(negedge clk);
        chk("out_valid", out_valid, 64'(exp_q.size() > ((m_mode == 2) ? 1 : 0)));
        chk("desc_valid", desc_valid, 64'(desc_q.size() != 0));
        chk("overrun", overrun, m_ovr);
        chk("dropped", dropped_frames, m_drop);
        in_start = st; in_strobe = sb; in_data = d;
        out_ready = ordy; desc_ready = drdy; clear_stats = clr;
        m_step(st, sb, d, clr);
        if (out_valid && ordy) begin
            chk("data_avail", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("data_word", {out_eof, out_sof, out_data}, exp_q.pop_front());
                last_word = {out_eof, out_sof, out_data};
                n_popped++;
            end
        end
        if (desc_valid && drdy) begin
            chk("desc_avail", 64'(desc_q.size() != 0), 1);
            if (desc_q.size() != 0) chk("desc_word", desc_data, desc_q.pop_front());
            got_desc.push_back(desc_data);
        end
    endtask

    task automatic frame(input int n, input logic [31:0] base, input logic ordy, input logic drdy);
        cyc(1'b1, 1'b0, '0, ordy, drdy, 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, base + 32'(i), ordy, drdy, 1'b0);
        cyc(1'b0, 1'b0, '0, ordy, drdy, 1'b0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || desc_q.size() != 0) && k < budget) begin
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            k++;
        end
        chk("drain_left", 64'(exp_q.size() + desc_q.size()), 0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_start = 1'b0; in_strobe = 1'b0; clear_stats = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete(); desc_q.delete();
        m_mode = 0; m_cnt = 0; m_seq = 8'hFF; m_idx = '0; m_ovr = 1'b0; m_drop = '0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dropped", dropped_frames, 0);
        chk("rst_out", {out_sof, out_eof, out_data}, 0);
        chk("rst_desc", desc_data, 0);
    endtask

    initial begin
        int p0, len, pr;
        logic st, clr;
        do_reset();

        // 300 words -> 128, 128, 44
        got_desc.delete(); p0 = n_popped;
        frame(300, 0, 1'b1, 1'b1);
        drain(500);
        chk("t1_words", n_popped - p0, 300);
        chk("t1_ndesc", got_desc.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got_desc.size())
                chk("t1_desc", got_desc[i], {8'd0, 8'(i), (i < 2) ? 16'd128 : 16'd44});

        // exact multiple, then single word frame
        got_desc.delete();
        frame(256, 1000, 1'b1, 1'b1);
        drain(500);
        chk("t2_ndesc", got_desc.size(), 2);
        if (got_desc.size() > 1) chk("t2_desc1", got_desc[1], {8'd1, 8'd1, 16'd128});
        got_desc.delete();
        frame(1, 5000, 1'b1, 1'b1);
        drain(100);
        chk("t2_single_flags", last_word[33:32], 2'b11);
        if (got_desc.size() > 0) chk("t2_single_desc", got_desc[0], {8'd2, 8'd0, 16'd1});

        // data FIFO fills: second frame admits one packet only
        got_desc.delete(); p0 = n_popped;
        frame(300, 0, 1'b0, 1'b1);
        frame(300, 300, 1'b0, 1'b1);
        chk("t3_overrun", overrun, 1);
        chk("t3_dropped", dropped_frames, 1);
        drain(2000);
        chk("t3_words", n_popped - p0, 428);
        chk("t3_ndesc", got_desc.size(), 4);
        if (got_desc.size() > 3) chk("t3_desc3", got_desc[3], {8'd4, 8'd0, 16'd128});

        // in_start together with the 50th strobe
        got_desc.delete();
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 49; i++) cyc(1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'd49, 1'b1, 1'b1, 1'b0);
        for (int i = 50; i < 70; i++) cyc(1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        drain(200);
        chk("t4_ndesc", got_desc.size(), 2);
        if (got_desc.size() > 1) begin
            chk("t4_desc0", got_desc[0], {8'd5, 8'd0, 16'd49});
            chk("t4_desc1", got_desc[1], {8'd6, 8'd0, 16'd21});
        end

        // descriptor FIFO full; drop coincides with clear_stats
        p0 = n_popped;
        for (int i = 0; i < 16; i++) frame(1, 32'(i), 1'b1, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'hAA, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_words", n_popped - p0, 16);
        chk("t5_overrun", overrun, 1);
        chk("t5_dropped", dropped_frames, 1);
        drain(200);

        // reset mid-burst
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        do_reset();
        got_desc.delete();
        frame(10, 77, 1'b1, 1'b1);
        drain(100);
        if (got_desc.size() > 0) chk("t6_desc", got_desc[0], {8'd0, 8'd0, 16'd10});
        else chk("t6_ndesc", got_desc.size(), 1);

        // random bursts, back-pressure, mid-burst restarts and stat clears
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 350);
            pr  = $urandom_range(0, 3);
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < len; i++) begin
                st  = ($urandom_range(0, 199) == 0);
                clr = ($urandom_range(0, 199) == 0);
                cyc(st, 1'b1, $urandom, ($urandom_range(0, 3) < pr), ($urandom_range(0, 3) != 0), clr);
            end
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            for (int g = $urandom_range(0, 5); g > 0; g--)
                cyc(1'b0, 1'b0, '0, ($urandom_range(0, 1) == 1), 1'b1, 1'b0);
        end
        drain(5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdu_rx_framer.md
Name: sdu_rx_framer

Overview:
- Downstream of the averaging receive stage. Consumes its 32-bit playback stream (data plus a one-cycle strobe per word, one burst per averaged acquisition) and splits each burst into packets of at most PKT_WORDS words.
- Buffers packets in a data FIFO with sof/eof sideband and emits one descriptor per packet on a separate descriptor FIFO for the host DMA.
- Input has no backpressure, so overflow is handled by whole-frame admission control.

Parameters:
- PKT_WORDS, 128: maximum payload words per packet. Legal range 1..65535, and PKT_WORDS+1 <= 2**DATA_AW.
- DATA_AW, 9: log2 depth of the data FIFO (512 entries, 34 bits each: data, sof, eof).
- DESC_AW, 4: log2 depth of the descriptor FIFO (16 entries x 32 bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_start  in  1  one-cycle pulse; starts a new frame
- in_data  in  32  sample word
- in_strobe  in  1  in_data valid this cycle
- out_data  out  32  data FIFO head word
- out_sof  out  1  head word is the first word of a packet
- out_eof  out  1  head word is the last word of a packet
- out_valid  out  1  data head valid (first-word fall-through)
- out_ready  in  1  pop data head when out_valid is also high
- desc_data  out  32  {frame_seq[7:0], pkt_idx[7:0], len[15:0]}
- desc_valid  out  1  descriptor head valid
- desc_ready  in  1  pop descriptor
- clear_stats  in  1  clears overrun and dropped_frames
- overrun  out  1  sticky; set when any frame is discarded
- dropped_frames  out  16  saturating count of discarded frames

Behaviour:
- Reset: both FIFOs empty; stage register invalid; state IDLE; frame_seq=0xFF (so the first frame is seq 0); pkt_idx=0; cnt=0.
  - All outputs are 0 after reset: out_valid, desc_valid, out_sof, out_eof, overrun, dropped_frames. out_data and desc_data are also 0.
  - Reset mid-frame discards everything, including buffered packets.
- Stage register: holds the newest accepted word, with a sof flag. It is written into the data FIFO when one of these happens:
  - the next word arrives (eof = 1 iff cnt == PKT_WORDS, otherwise 0);
  - the burst ends (eof = 1);
  - in_start arrives (eof = 1).
- One data-FIFO write per cycle at most. Every eof write also pushes a descriptor {frame_seq, pkt_idx, len = cnt}, then increments pkt_idx (8-bit wrap).
- States:
  - IDLE: in_strobe ignored. in_start -> FIRST, frame_seq++, pkt_idx=0.
  - FIRST: on in_strobe, run the admission check. Pass: load stage with sof=1, cnt=1 -> RUN. Fail -> DISCARD.
  - RUN:
    - in_strobe with cnt < PKT_WORDS: flush stage (eof=0), load the new word, cnt++.
    - in_strobe with cnt == PKT_WORDS: flush stage (eof=1 plus descriptor), then run the admission check for the new packet. Pass: load stage with sof=1, cnt=1. Fail -> DISCARD (the new word is dropped).
    - in_strobe low (burst end): flush stage (eof=1 plus descriptor) -> IDLE.
  - DISCARD: in_strobe ignored until in_start.
- Admission check: data_free >= PKT_WORDS+1 AND desc FIFO not full. Occupancy counts any write made in the same cycle.
  - On failure: overrun=1; dropped_frames++ (saturating at 0xFFFF), once per frame.
  - Packets already fully written for that frame stay valid and keep their descriptors.
- in_start in RUN flushes the stage (eof=1) and opens a new frame (frame_seq++, pkt_idx=0). If in_strobe is high in the same cycle, that word is the new frame's first word: admission check, then stage. in_start in DISCARD or FIRST behaves as it does in IDLE.
- Because packets are admitted against worst-case size, a packet's words are never dropped partway through, and eof is always written.
- Latency: a word accepted at edge E is written to the FIFO at the edge that takes the next word, or at the edge that sees the burst end. out_valid is high in the cycle after that FIFO write.
- A burst whose length is an exact multiple of PKT_WORDS produces no empty trailing packet. A single-word packet has sof=eof=1.
- A FIFO pop and push in the same cycle are both honoured. Output ordering is strictly FIFO.
- clear_stats has lower priority than a same-cycle set: if a frame is dropped in the same cycle, the result is overrun=1 and dropped_frames=1.

Test Plan:
- Frame of 300 words (values 0..299), ready held high -> packets of 128, 128, 44 words. sof on 0, 128, 256; eof on 127, 255, 299. Descriptors {0,0,128}, {0,1,128}, {0,2,44}.
- Frame of exactly 256 words -> 2 packets, 2 descriptors, no zero-length packet. Then a 1-word frame -> a single word with sof=eof=1 and descriptor {seq+1, 0, 1}.
- out_ready=0, DATA_AW=9, two 300-word frames -> frame 0 fully buffered. Frame 1 admits packet 0 only (128 words, descriptor {1,0,128}), then its second packet fails admission. overrun=1, dropped_frames=1. Draining then yields 428 words with exact sof/eof.
- in_start asserted in the same cycle as the 50th strobe of a burst -> first packet closes with len 49. The 50th word carries sof of frame seq+1.
- desc_ready=0 with 16 descriptors pending -> the next packet start is discarded; the data FIFO receives no partial packet.
- Reset pulsed mid-burst -> the next cycle shows out_valid=0, desc_valid=0, overrun=0. The next frame's descriptor has frame_seq=0.
